mux_pipe_arb: RTL

- Parametrised, registered N:1 datapath multiplexer; successor to the combinational 16-bit 2:1 datapath mux.
- Selects one of NCH WIDTH-bit source channels and registers it into a single output stage with valid/ready handshake.
- Two modes:
  - Direct select: the channel is given by the sel port.
  - Round-robin arbitration: fair sharing among requesting channels.
- Sits between multiple datapath producers (ALU, load unit, immediate path, PC path) and a shared writeback/bus consumer.

---
 rtl/mux_pipe_arb_if.sv | 27 ++
 rtl/mux_pipe_arb.sv | 81 ++++++++
 2 files changed

// File: rtl/mux_pipe_arb_if.sv
// Handshake bundle for mux_pipe_arb: NCH producer channels in, one registered consumer port out.
interface mux_pipe_arb_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_pipe_arb.sv
// Registered N:1 datapath mux with direct-select or round-robin grant and a
// single-entry valid/ready output stage.
module mux_pipe_arb #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_pipe_arb_if.slave bus
);
  localparam int SELW = $clog2(NCH);

  logic [SELW-1:0]  last;
  logic [SELW-1:0]  rr_grant;
  logic             rr_found;
  logic [SELW-1:0]  grant;
  logic             have_cand;
  logic             load_en;
  logic             xfer;
  logic [NCH-1:0]   ready;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  ch_q;
  logic             valid_q;

  // Round-robin search starts just after the last granted channel.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!rr_found && bus.in_valid[(int'(last) + i) % NCH]) begin
        rr_found = 1'b1;
        rr_grant = SELW'((int'(last) + i) % NCH);
      end
    end
  end

  // A sel beyond the channel count (non-power-of-2 NCH) names no channel.
  always_comb begin
    if (bus.mode) begin
      grant     = rr_grant;
      have_cand = rr_found;
    end else begin
      grant     = bus.sel;
      have_cand = int'(bus.sel) < NCH;
    end
  end

  assign load_en = !valid_q || bus.out_ready;

  // in_ready follows out_ready combinationally; the stage has no skid entry.
  always_comb begin
    ready = '0;
    if (rst_n && have_cand && load_en) ready[grant] = 1'b1;
  end

  assign xfer = have_cand && bus.in_valid[grant] && load_en && rst_n;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: every register here is reset asynchronously, including the data word, so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      last    <= SELW'(NCH - 1);
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
      ch_q    <= grant;
      if (bus.mode) last <= grant;
    end else if (load_en) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_ch    = ch_q;
endmodule
